// File: rtl/enigma_seq.sv
// Sequences one character through NUM_ROT rotor stages, then odometer-steps the rotors.
// Optional stage timeout: define ROT_TIMEOUT_EN.
module enigma_seq #(
    parameter int NUM_ROT = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cfg_set,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_char,
    input  logic                   in_dec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_char,
    output logic                   out_err,
    output logic                   rot_set,
    output logic [NUM_ROT-1:0]     rot_valid,
    output logic [NUM_ROT-1:0]     rot_en,
    output logic                   rot_dec,
    output logic [7:0]             rot_din,
    input  logic [NUM_ROT-1:0]     rot_done,
    input  logic [8*NUM_ROT-1:0]   rot_dout,
    output logic [2:0]             dbg_state
);
    localparam int SW = (NUM_ROT > 1) ? $clog2(NUM_ROT) : 1;
    localparam logic [SW-1:0] LAST = SW'(NUM_ROT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_STEP, S_OUT} state_e;

    state_e                   state_q, state_d;
    logic [SW-1:0]            stage_q, stage_d, last_stage;
    logic [7:0]               char_q, char_d, sel_dout;
    logic                     dec_q, dec_d;
    logic                     rdy_q, rdy_d;
    logic                     sel_done, carry, is_letter;
    logic [NUM_ROT-1:0][4:0]  pos_q, pos_d;
    logic [NUM_ROT-1:0]       en_c;
`ifdef ROT_TIMEOUT_EN
    logic [15:0]              cnt_q, cnt_d;
    logic                     err_q, err_d;
`endif

    always_comb begin
        sel_done = 1'b0;
        sel_dout = 8'd0;
        for (int k = 0; k < NUM_ROT; k++) begin
            if (stage_q == SW'(k)) begin
                sel_done = rot_done[k];
                sel_dout = rot_dout[8*k +: 8];
            end
        end
    end

    assign is_letter  = (in_char >= 8'd65) && (in_char <= 8'd90);
    assign last_stage = dec_q ? {SW{1'b0}} : LAST;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        char_d  = char_q;
        dec_d   = dec_q;
        pos_d   = pos_q;
        en_c    = '0;
        carry   = 1'b1;
`ifdef ROT_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                // rdy_q is low only in the first IDLE cycle after reset
                if (rdy_q && cfg_set) begin
                    pos_d = '0;
                end else if (rdy_q && in_valid) begin
                    char_d  = in_char;
                    dec_d   = in_dec;
                    stage_d = in_dec ? LAST : {SW{1'b0}};
                    state_d = is_letter ? S_ISSUE : S_OUT;
`ifdef ROT_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef ROT_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (sel_done) begin
                    char_d = sel_dout;
                    if (stage_q == last_stage) begin
                        state_d = S_STEP;
                    end else begin
                        stage_d = dec_q ? stage_q - 1'b1 : stage_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
`ifdef ROT_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    char_d  = 8'h3F;
                    err_d   = 1'b1;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            S_STEP: begin
                // a stage steps only when every lower stage steps and wraps
                for (int k = 0; k < NUM_ROT; k++) begin
                    en_c[k] = carry;
                    if (carry) begin
                        pos_d[k] = (pos_q[k] == 5'd25) ? 5'd0 : pos_q[k] + 5'd1;
                    end
                    carry = carry && (pos_q[k] == 5'd25);
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            char_q  <= 8'd0;
            dec_q   <= 1'b0;
            rdy_q   <= 1'b0;
            pos_q   <= '0;
`ifdef ROT_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            char_q  <= char_d;
            dec_q   <= dec_d;
            rdy_q   <= rdy_d;
            pos_q   <= pos_d;
`ifdef ROT_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign in_ready  = rdy_q & ~cfg_set;
    assign rot_set   = rdy_q & cfg_set;
    assign out_valid = (state_q == S_OUT);
    assign out_char  = char_q;
    assign rot_valid = (state_q == S_ISSUE) ? (NUM_ROT'(1) << stage_q) : '0;
    assign rot_en    = en_c;
    assign rot_dec   = dec_q;
    assign rot_din   = char_q;
    assign dbg_state = state_q;
`ifdef ROT_TIMEOUT_EN
    assign out_err   = err_q;
`else
    assign out_err   = 1'b0;
`endif
endmodule

// File: tb/tb_enigma_seq.sv
// Bench for enigma_seq: rotor models with offsets and random latency, odometer reference model.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module tb_enigma_seq;
    localparam int NR    = 3;
    localparam int TO    = 8;
    localparam int TOTAL = 26 * 26 * 26;

    logic            clk, reset_n, cfg_set, in_valid, in_ready, in_dec;
    logic [7:0]      in_char, out_char, rot_din;
    logic            out_valid, out_ready, out_err, rot_set, rot_dec;
    logic [NR-1:0]   rot_valid, rot_en, rot_done;
    logic [8*NR-1:0] rot_dout;
    logic [2:0]      dbg_state;

    enigma_seq #(.NUM_ROT(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_set(cfg_set),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_dec(in_dec),
        .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char), .out_err(out_err),
        .rot_set(rot_set), .rot_valid(rot_valid), .rot_en(rot_en), .rot_dec(rot_dec),
        .rot_din(rot_din), .rot_done(rot_done), .rot_dout(rot_dout), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // rotor models and monitor state
    int            off [NR];
    bit            mute [NR];
    bit            busy [NR];
    int            dly [NR];
    logic [7:0]    res [NR];
    int            max_dly = 0;
    int            order_q [$];
    bit            cur_dec = 0;
    int            en_pulses = 0;
    logic [NR-1:0] en_last = '0;
    int            step_cnt = 0;

    typedef struct {
        logic [7:0]    ch;
        bit            dec;
        int            hold;
        logic [7:0]    exp_ch;
        logic [NR-1:0] exp_en;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] shift(input logic [7:0] c, input int d);
        int v;
        v = (int'(c) - 65 + d) % 26;
        if (v < 0) v += 26;
        return 8'(65 + v);
    endfunction

    function automatic bit letter(input logic [7:0] c);
        return c >= 65 && c <= 90;
    endfunction

    function automatic int digit(input int v, input int k);
        int x;
        x = v;
        for (int i = 0; i < k; i++) x = x / 26;
        return x % 26;
    endfunction

    // clock / reset
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // rotor models + pulse monitor, all on the falling edge
    always @(negedge clk) begin
        if (!reset_n) begin
            rot_done = '0;
            rot_dout = '0;
            for (int k = 0; k < NR; k++) busy[k] = 0;
        end else begin
            rot_done = '0;
            for (int k = 0; k < NR; k++) begin
                if (busy[k]) begin
                    if (dly[k] == 0) begin
                        rot_done[k] = 1'b1;
                        rot_dout[8*k +: 8] = res[k];
                        busy[k] = 0;
                    end else begin
                        dly[k]--;
                    end
                end
            end
            for (int k = 0; k < NR; k++) begin
                if (rot_valid[k]) begin
                    busy[k] = !mute[k];
                    dly[k]  = $urandom_range(0, max_dly);
                    res[k]  = shift(rot_din, rot_dec ? -off[k] : off[k]);
                    order_q.push_back(k);
                    chk("rot_dec", rot_dec, cur_dec);
                end
            end
            if (rot_en != '0) begin
                en_pulses++;
                en_last = rot_en;
            end
            if (|{rot_valid, rot_en, rot_set})
                chk("pulse_exclusive", $countones({|rot_valid, |rot_en, rot_set}), 1);
            if (rot_valid != '0)
                chk("rot_valid_onehot", $countones(rot_valid), 1);
        end
    end

    // driver tasks
    task automatic accept(input logic [7:0] ch, input bit dec);
        int g;
        g = 0;
        cur_dec = dec;
        order_q.delete();
        en_pulses = 0;
        en_last = '0;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("in_ready_seen", in_ready, 1);
        in_valid = 1; in_char = ch; in_dec = dec;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic collect(input int hold, output logic [7:0] got, output logic gerr, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 400);
        chk("out_valid_seen", out_valid, 1);
        got  = out_char;
        gerr = out_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_char", out_char, got);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        chk("out_valid_drop", out_valid, 0);
    endtask

    task automatic check_order(input bit is_let, input bit dec);
        chk("order_len", order_q.size(), is_let ? NR : 0);
        if (is_let && order_q.size() == NR)
            for (int k = 0; k < NR; k++) chk("order", order_q[k], dec ? NR - 1 - k : k);
    endtask

    // reference: sum of offsets for the character, base-26 odometer for stepping
    task automatic verify(input logic [7:0] ch, input bit dec, input logic [7:0] got, input logic gerr);
        int sum;
        bit all;
        logic [NR-1:0] e;
        logic [7:0] exp_c;
        sum = 0;
        for (int k = 0; k < NR; k++) sum += off[k];
        exp_c = letter(ch) ? shift(ch, dec ? -sum : sum) : ch;
        e = '0;
        if (letter(ch)) begin
            all = 1;
            for (int k = 0; k < NR; k++) begin
                e[k] = all;
                all = all && (digit(step_cnt, k) == 25);
            end
            step_cnt = (step_cnt + 1) % TOTAL;
        end
        chk("out_char", got, exp_c);
        chk("out_err", gerr, 0);
        chk("rot_en", en_last, e);
        chk("en_pulses", en_pulses, letter(ch) ? 1 : 0);
        check_order(letter(ch), dec);
    endtask

    task automatic txn(input logic [7:0] ch, input bit dec, input int hold);
        logic [7:0] got;
        logic gerr;
        int lat;
        accept(ch, dec);
        collect(hold, got, gerr, lat);
        verify(ch, dec, got, gerr);
    endtask

    task automatic preload(input logic [NR-1:0][4:0] p, input int cnt);
        @(negedge clk);
        force dut.pos_q = p;
        @(posedge clk);
        #1 release dut.pos_q;
        step_cnt = cnt;
    endtask

    initial begin
        logic [7:0] got;
        logic gerr;
        int lat;
        int seen;

        tbl[0] = '{8'd65, 0, 0, 8'd68, 3'b001};  // 'A' -> 'D'
        tbl[1] = '{8'd68, 1, 0, 8'd65, 3'b001};  // 'D' -> 'A'
        tbl[2] = '{8'd53, 0, 5, 8'd53, 3'b000};  // '5' bypass, output held
        tbl[3] = '{8'd90, 0, 1, 8'd67, 3'b001};  // 'Z' -> 'C'
        tbl[4] = '{8'd66, 1, 0, 8'd89, 3'b001};  // 'B' -> 'Y'
        tbl[5] = '{8'd64, 0, 0, 8'd64, 3'b000};  // '@' just below range
        tbl[6] = '{8'd91, 1, 0, 8'd91, 3'b000};  // '[' just above range
        tbl[7] = '{8'd97, 0, 2, 8'd97, 3'b000};  // lower case passes through
        tbl[8] = '{8'd77, 0, 0, 8'd80, 3'b001};  // 'M' -> 'P'

        for (int k = 0; k < NR; k++) begin
            off[k] = 1;
            mute[k] = 0;
        end
        reset_n = 0; cfg_set = 0; in_valid = 0; in_char = 0; in_dec = 0; out_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_char", out_char, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_pulses", {rot_set, rot_valid, rot_en}, 0);
        chk("rst_rot_dec", rot_dec, 0);
        chk("rst_rot_din", rot_din, 0);
        reset_n = 1;
        #1 chk("first_cycle_in_ready", in_ready, 0);
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        for (int i = 0; i < 9; i++) begin
            accept(tbl[i].ch, tbl[i].dec);
            collect(tbl[i].hold, got, gerr, lat);
            chk("tbl_char", got, tbl[i].exp_ch);
            chk("tbl_err", gerr, 0);
            chk("tbl_en", en_last, tbl[i].exp_en);
            check_order(letter(tbl[i].ch), tbl[i].dec);
            if (!letter(tbl[i].ch)) chk("bypass_latency", lat, 1);
            if (letter(tbl[i].ch)) step_cnt++;
        end

        // 26 encodes after a config clear: the 26th step carries into stage 1
        @(negedge clk);
        cfg_set = 1;
        @(posedge clk);
        #1 cfg_set = 0;
        step_cnt = 0;
        max_dly = 2;
        for (int i = 0; i < 26; i++) txn(8'(65 + $urandom_range(0, 25)), 0, 0);
        chk("step26_en", en_last, 3'b011);

        // all stages at 25: every rotor steps together, then wraps to zero
        preload({5'd25, 5'd25, 5'd25}, TOTAL - 1);
        txn(8'd65, 0, 0);
        chk("all_step_en", en_last, 3'b111);
        txn(8'd65, 0, 0);
        chk("after_wrap_en", en_last, 3'b001);

        // cfg_set with in_valid: cfg wins, character taken next cycle, positions cleared
        preload({5'd0, 5'd0, 5'd25}, 25);
        cur_dec = 0; order_q.delete(); en_pulses = 0; en_last = '0;
        @(negedge clk);
        cfg_set = 1; in_valid = 1; in_char = 8'd65; in_dec = 0;
        #1;
        chk("cfg_in_ready", in_ready, 0);
        chk("cfg_rot_set", rot_set, 1);
        @(posedge clk);
        #1 cfg_set = 0;
        step_cnt = 0;
        @(negedge clk);
        chk("cfg_after_ready", in_ready, 1);
        chk("cfg_set_single", rot_set, 0);
        @(posedge clk);
        #1 in_valid = 0;
        collect(0, got, gerr, lat);
        verify(8'd65, 0, got, gerr);

        // cfg_set while busy is ignored
        accept(8'd72, 1);
        @(negedge clk);
        cfg_set = 1;
        #1 chk("cfg_busy_rot_set", rot_set, 0);
        @(negedge clk);
        cfg_set = 0;
        collect(0, got, gerr, lat);
        verify(8'd72, 1, got, gerr);

        // randomized traffic
        max_dly = 3;
        for (int i = 0; i < 60; i++) begin
            logic [7:0] c;
            for (int k = 0; k < NR; k++) off[k] = $urandom_range(0, 25);
            c = ($urandom_range(0, 9) < 7) ? 8'(65 + $urandom_range(0, 25)) : 8'($urandom_range(0, 255));
            txn(c, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

`ifdef ROT_TIMEOUT_EN
        // silent rotor: abort with '?' and no stepping
        max_dly = 0;
        mute[1] = 1;
        accept(8'd75, 0);
        collect(0, got, gerr, lat);
        chk("timeout_err", gerr, 1);
        chk("timeout_char", got, 8'h3F);
        chk("timeout_no_step", en_pulses, 0);
        mute[1] = 0;
        txn(8'd75, 0, 0);
`endif

        // reset while waiting on a silent rotor
        max_dly = 0;
        mute[1] = 1;
        accept(8'd81, 0);
        repeat (4) @(negedge clk);
        reset_n = 0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_char", out_char, 0);
        chk("mid_rst_out_err", out_err, 0);
        chk("mid_rst_pulses", {rot_set, rot_valid, rot_en}, 0);
        chk("mid_rst_rot_dec", rot_dec, 0);
        chk("mid_rst_rot_din", rot_din, 0);
        @(negedge clk);
        reset_n = 1;
        mute[1] = 0;
        step_cnt = 0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_out_after_rst", seen, 0);
        chk("ready_after_rst", in_ready, 1);
        off[0] = 3; off[1] = 5; off[2] = 7;
        txn(8'd70, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
